// File: rtl/calc_rpn_core.sv
// calc_rpn_core: RPN calculator engine. Takes decoded key events, keeps a signed
// operand stack and a digit-entry register, and drives the sign-magnitude display
// value plus error/depth status.
// Ports: clk, reset (async active-low), ev/key (one key per ev pulse, no backpressure),
//   value/neg/valid (displayed operand), err (sticky), depth (stack occupancy),
//   disp_en (one-cycle reload pulse, one cycle after each accepted key).
// Optional feature macro: CALC_RPN_MUL_EN enables key 0xC as multiply; when it is
//   undefined, 0xC is ignored and no multiplier exists.
module calc_rpn_core #(
  parameter int VAL_W       = 36,
  parameter int MAX_DIGITS  = 9,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ev,
  input  logic [3:0]                         key,
  output logic [VAL_W-1:0]                   value,
  output logic                               neg,
  output logic                               valid,
  output logic                               err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               disp_en
);

  localparam int EW = VAL_W + 1;
  localparam int PW = 2 * EW;
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int NW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  function automatic logic [PW-1:0] pow10(input int n);
    logic [PW-1:0] p;
    p = PW'(1);
    for (int i = 0; i < n; i++) p = p * PW'(10);
    return p;
  endfunction

  // Largest legal magnitude of any entry or result.
  localparam logic signed [PW-1:0] LIM = pow10(MAX_DIGITS) - PW'(1);
  localparam logic signed [EW-1:0] TEN = EW'(10);

  logic [1:0]             state_q, state_d;
  logic signed [EW-1:0]   entry_q, entry_d;
  logic [NW-1:0]          ndig_q, ndig_d;
  logic [DW-1:0]          depth_q, depth_d;
  logic                   disp_en_q, disp_en_d;
  // Index 0 is the top of stack; pushes shift everything toward higher indices.
  logic signed [EW-1:0]   stk_q [STACK_DEPTH];
  logic signed [EW-1:0]   stk_d [STACK_DEPTH];

  logic                   ok, is_op;
  logic [DW-1:0]          dtmp;
  logic signed [EW-1:0]   dv, x, y, pv, src;
  logic signed [PW-1:0]   r_wide;

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    ndig_d    = ndig_q;
    depth_d   = depth_q;
    stk_d     = stk_q;
    disp_en_d = 1'b0;
    ok        = 1'b1;
    dtmp      = depth_q;
    dv        = $signed(EW'(key));
    x         = stk_q[0];
    y         = stk_q[1];
    pv        = (state_q == S_ENTRY) ? entry_q : stk_q[0];
    r_wide    = '0;
    is_op     = (key == 4'hA) || (key == 4'hB)
`ifdef CALC_RPN_MUL_EN
                || (key == 4'hC)
`endif
                ;

    if (ev) begin
      if (key == 4'hF) begin
        state_d   = S_IDLE;
        entry_d   = '0;
        ndig_d    = '0;
        depth_d   = '0;
        disp_en_d = 1'b1;
        for (int i = 0; i < STACK_DEPTH; i++) stk_d[i] = '0;
      end else if (state_q != S_ERROR) begin
        if (key <= 4'd9) begin
          // While E is zero, leading zeros do not consume the digit budget.
          if (state_q != S_ENTRY || entry_q == '0) begin
            entry_d   = dv;
            ndig_d    = (key != 4'd0) ? NW'(1) : '0;
            state_d   = S_ENTRY;
            disp_en_d = 1'b1;
          end else if (ndig_q < NW'(MAX_DIGITS)) begin
            // A negated entry keeps growing in magnitude.
            entry_d   = entry_q[EW-1] ? entry_q * TEN - dv : entry_q * TEN + dv;
            ndig_d    = ndig_q + NW'(1);
            disp_en_d = 1'b1;
          end
        end else if (key == 4'hD) begin
          if (state_q == S_ENTRY || depth_q != '0) begin
            disp_en_d = 1'b1;
            if (depth_q == DW'(STACK_DEPTH)) begin
              state_d = S_ERROR;
            end else begin
              for (int i = STACK_DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
              stk_d[0] = pv;
              depth_d  = depth_q + DW'(1);
              state_d  = S_IDLE;
              entry_d  = '0;
              ndig_d   = '0;
            end
          end
        end else if (is_op) begin
          disp_en_d = 1'b1;
          if (state_q == S_ENTRY) begin
            if (depth_q == DW'(STACK_DEPTH)) begin
              ok = 1'b0;
            end else begin
              for (int i = STACK_DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
              stk_d[0] = entry_q;
              dtmp     = depth_q + DW'(1);
            end
          end
          if (dtmp < DW'(2)) ok = 1'b0;
          x = stk_d[0];
          y = stk_d[1];
          if (key == 4'hA)      r_wide = PW'(y) + PW'(x);
          else if (key == 4'hB) r_wide = PW'(y) - PW'(x);
`ifdef CALC_RPN_MUL_EN
          else                  r_wide = PW'(y) * PW'(x);
`endif
          if (r_wide > LIM || r_wide < -LIM) ok = 1'b0;
          if (ok) begin
            stk_d[0] = r_wide[EW-1:0];
            for (int i = 1; i < STACK_DEPTH - 1; i++) stk_d[i] = stk_d[i+1];
            stk_d[STACK_DEPTH-1] = '0;
            depth_d = dtmp - DW'(1);
            state_d = S_IDLE;
            entry_d = '0;
            ndig_d  = '0;
          end else begin
            // Failed operation leaves the stack exactly as it was before the key.
            stk_d   = stk_q;
            depth_d = depth_q;
            state_d = S_ERROR;
          end
        end else if (key == 4'hE) begin
          if (state_q == S_ENTRY) begin
            entry_d   = -entry_q;
            disp_en_d = 1'b1;
          end else if (depth_q != '0) begin
            stk_d[0]  = -stk_q[0];
            disp_en_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      entry_q   <= '0;
      ndig_q    <= '0;
      depth_q   <= '0;
      disp_en_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      ndig_q    <= ndig_d;
      depth_q   <= depth_d;
      disp_en_q <= disp_en_d;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= stk_d[i];
    end
  end

  always_comb begin
    if (state_q == S_ENTRY)                      src = entry_q;
    else if (state_q == S_IDLE && depth_q != '0) src = stk_q[0];
    else                                         src = '0;
  end

  // -0 has a clear sign bit, so it shows as positive zero.
  assign neg     = src[EW-1];
  assign value   = neg ? VAL_W'(-src) : VAL_W'(src);
  assign valid   = (state_q != S_ERROR);
  assign err     = (state_q == S_ERROR);
  assign depth   = depth_q;
  assign disp_en = disp_en_q;

endmodule

// File: tb/tb_calc_rpn_core.sv
module tb_calc_rpn_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        ev;
  logic [3:0]  key;
  logic [35:0] value;
  logic        neg, valid, err, disp_en;
  logic [2:0]  depth;

  calc_rpn_core dut (
    .clk(clk), .reset(reset), .ev(ev), .key(key),
    .value(value), .neg(neg), .valid(valid), .err(err),
    .depth(depth), .disp_en(disp_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  k;
    logic [35:0] v;
    logic        n;
    logic        vl;
    logic        er;
    logic [2:0]  d;
    logic        de;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Accepted key, legal result displayed.
  function automatic vec_t num(input logic [3:0] k, input logic [35:0] v, input logic n,
                               input logic [2:0] d);
    vec_t e;
    e.k = k; e.v = v; e.n = n; e.vl = 1'b1; e.er = 1'b0; e.d = d; e.de = 1'b1;
    return e;
  endfunction

  // Ignored key in a non-error state: display unchanged, no reload pulse.
  function automatic vec_t ign(input logic [3:0] k, input logic [35:0] v, input logic [2:0] d);
    vec_t e;
    e = num(k, v, 1'b0, d);
    e.de = 1'b0;
    return e;
  endfunction

  // Key that lands in (or stays in) the error state.
  function automatic vec_t bad(input logic [3:0] k, input logic [2:0] d, input logic de);
    vec_t e;
    e.k = k; e.v = '0; e.n = 1'b0; e.vl = 1'b0; e.er = 1'b1; e.d = d; e.de = de;
    return e;
  endfunction

  task automatic check_out(input string name, input vec_t e);
    checks++;
    if (value !== e.v || neg !== e.n || valid !== e.vl || err !== e.er ||
        depth !== e.d || disp_en !== e.de) begin
      errors++;
      $display("FAIL %s: got value=%0d neg=%0b valid=%0b err=%0b depth=%0d disp_en=%0b, want value=%0d neg=%0b valid=%0b err=%0b depth=%0d disp_en=%0b",
               name, value, neg, valid, err, depth, disp_en,
               e.v, e.n, e.vl, e.er, e.d, e.de);
    end
  endtask

  task automatic sb_check(input string name);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty when output was due", name);
    end else begin
      e = exp_q.pop_front();
      check_out(name, e);
    end
  endtask

  task automatic press(input vec_t e, input string name);
    @(negedge clk);
    ev  = 1'b1;
    key = e.k;
    exp_q.push_back(e);
    @(negedge clk);
    ev  = 1'b0;
    sb_check(name);
  endtask

  initial begin
    vec_t rst_v;
    reset = 1'b0;
    ev    = 1'b0;
    key   = 4'h0;
    rst_v = ign(4'h0, 36'd0, 3'd0);

    repeat (2) @(negedge clk);
    check_out("reset_state", rst_v);
    reset = 1'b1;

    // 1 2 ENTER 3 ADD -> 15
    tbl.push_back(num(4'h1, 36'd1, 1'b0, 3'd0));
    tbl.push_back(num(4'h2, 36'd12, 1'b0, 3'd0));
    tbl.push_back(num(4'hD, 36'd12, 1'b0, 3'd1));
    tbl.push_back(num(4'h3, 36'd3, 1'b0, 3'd1));
    tbl.push_back(num(4'hA, 36'd15, 1'b0, 3'd1));
    tbl.push_back(num(4'hF, 36'd0, 1'b0, 3'd0));
    // 5 ENTER 8 SUB -> -3, CHS -> 3
    tbl.push_back(num(4'h5, 36'd5, 1'b0, 3'd0));
    tbl.push_back(num(4'hD, 36'd5, 1'b0, 3'd1));
    tbl.push_back(num(4'h8, 36'd8, 1'b0, 3'd1));
    tbl.push_back(num(4'hB, 36'd3, 1'b1, 3'd1));
    tbl.push_back(num(4'hE, 36'd3, 1'b0, 3'd1));
    tbl.push_back(num(4'hF, 36'd0, 1'b0, 3'd0));
    // Ten 9s: the tenth is dropped; then overflow on ADD
    tbl.push_back(num(4'h9, 36'd9, 1'b0, 3'd0));
    tbl.push_back(num(4'h9, 36'd99, 1'b0, 3'd0));
    tbl.push_back(num(4'h9, 36'd999, 1'b0, 3'd0));
    tbl.push_back(num(4'h9, 36'd9999, 1'b0, 3'd0));
    tbl.push_back(num(4'h9, 36'd99999, 1'b0, 3'd0));
    tbl.push_back(num(4'h9, 36'd999999, 1'b0, 3'd0));
    tbl.push_back(num(4'h9, 36'd9999999, 1'b0, 3'd0));
    tbl.push_back(num(4'h9, 36'd99999999, 1'b0, 3'd0));
    tbl.push_back(num(4'h9, 36'd999999999, 1'b0, 3'd0));
    tbl.push_back(ign(4'h9, 36'd999999999, 3'd0));
    tbl.push_back(num(4'hD, 36'd999999999, 1'b0, 3'd1));
    tbl.push_back(num(4'h1, 36'd1, 1'b0, 3'd1));
    tbl.push_back(bad(4'hA, 3'd1, 1'b1));
    tbl.push_back(bad(4'h4, 3'd1, 1'b0));
    tbl.push_back(num(4'hF, 36'd0, 1'b0, 3'd0));
    // Fill the stack, then one more push overflows
    tbl.push_back(num(4'h1, 36'd1, 1'b0, 3'd0));
    tbl.push_back(num(4'hD, 36'd1, 1'b0, 3'd1));
    tbl.push_back(num(4'h2, 36'd2, 1'b0, 3'd1));
    tbl.push_back(num(4'hD, 36'd2, 1'b0, 3'd2));
    tbl.push_back(num(4'h3, 36'd3, 1'b0, 3'd2));
    tbl.push_back(num(4'hD, 36'd3, 1'b0, 3'd3));
    tbl.push_back(num(4'h4, 36'd4, 1'b0, 3'd3));
    tbl.push_back(num(4'hD, 36'd4, 1'b0, 3'd4));
    tbl.push_back(num(4'h5, 36'd5, 1'b0, 3'd4));
    tbl.push_back(bad(4'hD, 3'd4, 1'b1));
    tbl.push_back(num(4'hF, 36'd0, 1'b0, 3'd0));
    // Underflow: 7 ADD on an empty stack
    tbl.push_back(num(4'h7, 36'd7, 1'b0, 3'd0));
    tbl.push_back(bad(4'hA, 3'd0, 1'b1));
    tbl.push_back(num(4'hF, 36'd0, 1'b0, 3'd0));
    // ENTER and CHS on an empty stack are ignored
    tbl.push_back(ign(4'hD, 36'd0, 3'd0));
    tbl.push_back(ign(4'hE, 36'd0, 3'd0));
    // ENTER in IDLE duplicates the top
    tbl.push_back(num(4'h5, 36'd5, 1'b0, 3'd0));
    tbl.push_back(num(4'hD, 36'd5, 1'b0, 3'd1));
    tbl.push_back(num(4'hD, 36'd5, 1'b0, 3'd2));
    tbl.push_back(num(4'hA, 36'd10, 1'b0, 3'd1));
    tbl.push_back(num(4'hF, 36'd0, 1'b0, 3'd0));
    // Leading zeros
    tbl.push_back(num(4'h0, 36'd0, 1'b0, 3'd0));
    tbl.push_back(num(4'h0, 36'd0, 1'b0, 3'd0));
    tbl.push_back(num(4'h7, 36'd7, 1'b0, 3'd0));
    tbl.push_back(num(4'hF, 36'd0, 1'b0, 3'd0));
    // 12 ENTER 11 MUL
    tbl.push_back(num(4'h1, 36'd1, 1'b0, 3'd0));
    tbl.push_back(num(4'h2, 36'd12, 1'b0, 3'd0));
    tbl.push_back(num(4'hD, 36'd12, 1'b0, 3'd1));
    tbl.push_back(num(4'h1, 36'd1, 1'b0, 3'd1));
    tbl.push_back(num(4'h1, 36'd11, 1'b0, 3'd1));
`ifdef CALC_RPN_MUL_EN
    tbl.push_back(num(4'hC, 36'd132, 1'b0, 3'd1));
`else
    tbl.push_back(ign(4'hC, 36'd11, 3'd1));
`endif
    tbl.push_back(num(4'hF, 36'd0, 1'b0, 3'd0));

    foreach (tbl[i]) press(tbl[i], $sformatf("vec%0d_key%0h", i, tbl[i].k));

    // The pulse must not linger once no key arrives.
    @(negedge clk);
    check_out("disp_en_idle", ign(4'h0, 36'd0, 3'd0));

    // Reset mid-entry, coincident with a key event.
    press(num(4'h4, 36'd4, 1'b0, 3'd0), "rst_seq_4");
    press(num(4'h2, 36'd42, 1'b0, 3'd0), "rst_seq_42");
    @(negedge clk);
    ev    = 1'b1;
    key   = 4'h6;
    reset = 1'b0;
    #1;
    check_out("rst_async", rst_v);
    @(negedge clk);
    check_out("rst_held_with_ev", rst_v);
    reset = 1'b1;
    ev    = 1'b0;
    press(num(4'h6, 36'd6, 1'b0, 3'd0), "after_rst_6");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_rpn_core.md
Name: calc_rpn_core

Overview:
Parametrised RPN calculator engine, the successor to the fixed main controller in the calc top level. Consumes decoded keypad events (one 4-bit key code per ev pulse) and maintains a signed operand stack of configurable depth plus a digit-entry register. Drives sign-magnitude value/neg to the display and scoreboard, a disp_en refresh pulse, and error/depth status. Sits between input_control and display.

Parameters:
VAL_W, 36, width of value magnitude output; internal signed datapath is VAL_W+1 bits
MAX_DIGITS, 9, maximum decimal digits per entry and per result; requires 10^MAX_DIGITS <= 2^VAL_W
STACK_DEPTH, 4, number of operand stack entries (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
ev  input  1  single-cycle key event strobe
key  input  4  key code, sampled when ev=1
value  output  VAL_W  magnitude of displayed operand
neg  output  1  sign of displayed operand (1 = negative)
valid  output  1  1 when value is a legal number, 0 in error
err  output  1  sticky error flag
depth  output  $clog2(STACK_DEPTH+1)  occupied stack entries
disp_en  output  1  one-cycle pulse: display must reload value/neg

Behaviour:
- Reset (reset=0, async): stack empty, entry cleared, state IDLE; value=0, neg=0, valid=1, err=0, depth=0, disp_en=0. Reset wins over a simultaneous ev.
- Key codes: 0x0-0x9 digit; 0xA ADD; 0xB SUB; 0xC MUL (optional); 0xD ENTER; 0xE CHS; 0xF CLEAR.
- States: IDLE (no entry in progress), ENTRY (digits being typed), ERROR.
- One event accepted per cycle, no backpressure; ev with key at cycle n -> all outputs updated and disp_en=1 at cycle n+1. Ignored keys produce no disp_en.
- Digit: IDLE -> ENTRY, E=d. ENTRY: E=E*10+d if digit count < MAX_DIGITS, else ignored (no disp_en). Leading zeros do not count toward the limit while E=0.
- ENTER: in ENTRY push E, go IDLE; in IDLE duplicate top (depth>=1); empty stack -> ignored. Push with depth==STACK_DEPTH -> ERROR.
- ADD/SUB/MUL: if in ENTRY, E is pushed first (full-stack check applies). Then requires depth>=2, else ERROR. Pops Y (below) and X (top), pushes Y+X / Y-X / Y*X; depth decreases by 1; state IDLE.
- Result range: |r| <= 10^MAX_DIGITS-1, else ERROR. MUL uses a 2*(VAL_W+1)-bit product for the range check.
- CHS: in ENTRY negate E; in IDLE negate top if depth>=1, else ignored. -0 displays as neg=0.
- CLEAR: from any state, including ERROR: empty stack, clear E, err=0, state IDLE, disp_en pulse.
- ERROR: err=1, valid=0, value=0, neg=0; stack contents frozen; all keys except CLEAR ignored.
- Display source: ENTRY -> E; IDLE with depth>=1 -> top; otherwise 0.
- depth reflects stack after the event, same cycle as value.

Optional Feature:
CALC_RPN_MUL_EN: defined -> key 0xC performs MUL as specified. Undefined -> 0xC ignored in all states (no state change, no disp_en) and no multiplier is synthesised.

Test Plan:
- Reset, then keys 1,2,ENTER,3,ADD -> value=15, neg=0, depth=1, valid=1; disp_en pulses once per accepted key.
- 5,ENTER,8,SUB -> value=3, neg=1; then CHS -> value=3, neg=0.
- Ten 9s with MAX_DIGITS=9 -> value=999999999, 10th digit gives no disp_en; ENTER,1,ADD -> err=1, valid=0, value=0; next key 4 is ignored; CLEAR -> err=0, value=0, depth=0.
- With STACK_DEPTH=4, push 1..4 via ENTER, then 5,ENTER -> ERROR. Separately, 7,ADD on an empty stack -> ERROR (underflow).
- CALC_RPN_MUL_EN defined: 1,2,ENTER,1,1,MUL -> value=132. Undefined: same sequence leaves value=11, depth=1, and MUL gives no disp_en.
- Assert reset low mid-entry (after 4,2) and coincident with an ev -> outputs at reset values immediately; after release, key 6 -> value=6.
